// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and the game controller:
// receiver state encoding, prefix codes and the W/A/S/D make codes.
package ps2_keyboard_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;

    // Odd parity holds when data and parity bit together carry an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Decoded keyboard output bus: new-code strobe, code value and error pulse.
interface ps2_keyboard_rx_if;
    logic       kbstrobe;
    logic [7:0] kbcode;
    logic       kberr;

    modport master (output kbstrobe, output kbcode, output kberr);
    modport slave  (input  kbstrobe, input  kbcode, input  kberr);
endinterface

// File: rtl/ps2_input_filter.sv
// Synchronizes the raw PS/2 lines and debounces PS2CLK; emits a one-cycle
// bit event on each filtered falling edge together with the sampled data bit.
module ps2_input_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic CLK,
    input  logic ARST,
    input  logic ps2clk_i,
    input  logic ps2data_i,
    output logic data_o,
    output logic bit_event_o
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            flt_q, flt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            event_q, event_d;
    logic            data_q, data_d;

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            flt_q       <= 1'b1;
            cnt_q       <= '0;
            event_q     <= 1'b0;
            data_q      <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2clk_i};
            data_sync_q <= {data_sync_q[0], ps2data_i};
            flt_q       <= flt_d;
            cnt_q       <= cnt_d;
            event_q     <= event_d;
            data_q      <= data_d;
        end
    end

    // Count consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the count, so short glitches never flip it.
    always_comb begin
        flt_d   = flt_q;
        cnt_d   = '0;
        event_d = 1'b0;
        data_d  = data_q;
        if (clk_sync_q[1] != flt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                flt_d   = clk_sync_q[1];
                event_d = flt_q;
                data_d  = data_sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign data_o      = data_q;
    assign bit_event_o = event_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver: decodes 11-bit frames into make codes,
// swallowing break/extended prefixes and flagging framing/parity/timeout errors.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              CLK,
    input  logic              ARST,
    input  logic              PS2CLK,
    input  logic              PS2DATA,
    ps2_keyboard_rx_if.master kb
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

    logic bit_data, bit_event;

    ps2_input_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .CLK        (CLK),
        .ARST       (ARST),
        .ps2clk_i   (PS2CLK),
        .ps2data_i  (PS2DATA),
        .data_o     (bit_data),
        .bit_event_o(bit_event)
    );

    rx_state_e      state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           parity_q, parity_d;
    logic           brk_q, brk_d;
    logic           ext_q, ext_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]     code_q, code_d;
    logic           strobe_q, strobe_d;
    logic           err_q, err_d;

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            to_cnt_q  <= '0;
            code_q    <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            to_cnt_q  <= to_cnt_d;
            code_q    <= code_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        to_cnt_d  = to_cnt_q;
        code_d    = code_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;

        if (bit_event) begin
            to_cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (!bit_data) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {bit_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    parity_d = bit_data;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (bit_data && odd_parity_ok(shift_q, parity_q)) begin
                        if (shift_q == BREAK_CODE) begin
                            brk_d = 1'b1;
                        end else if (shift_q == EXT_CODE) begin
                            ext_d = 1'b1;
                        end else begin
                            // A code following the break prefix is a key release.
                            if (!brk_q) begin
                                code_d   = shift_q;
                                strobe_d = 1'b1;
                            end
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
            endcase
        end else if (state_q != StIdle) begin
            if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
                err_d     = 1'b1;
                state_d   = StIdle;
                shift_d   = '0;
                bit_cnt_d = '0;
                brk_d     = 1'b0;
                ext_d     = 1'b0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    assign kb.kbstrobe = strobe_q;
    assign kb.kbcode   = code_q;
    assign kb.kberr    = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-banged PS/2 frames with expected
// strobe/error counts and codes worked out by hand per scenario.
module tb_ps2_keyboard_rx;
    import ps2_keyboard_rx_pkg::*;

    localparam int unsigned FILT = 8;
    localparam int unsigned TO   = 2000;
    localparam int unsigned HALF = 50;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic ps2clk = 1'b1;
    logic ps2data = 1'b1;

    ps2_keyboard_rx_if kb ();

    ps2_keyboard_rx #(
        .FILTER_LEN (FILT),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK    (clk),
        .ARST   (arst),
        .PS2CLK (ps2clk),
        .PS2DATA(ps2data),
        .kb     (kb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int long_cnt = 0;
    int both_cnt = 0;
    logic strobe_prev = 1'b0;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        if (kb.kbstrobe && !strobe_prev) strobe_cnt <= strobe_cnt + 1;
        if (kb.kberr && !err_prev) err_cnt <= err_cnt + 1;
        if ((kb.kbstrobe && strobe_prev) || (kb.kberr && err_prev)) long_cnt <= long_cnt + 1;
        if (kb.kbstrobe && kb.kberr) both_cnt <= both_cnt + 1;
        strobe_prev <= kb.kbstrobe;
        err_prev    <= kb.kberr;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first nbits of a frame; glitch adds 3-cycle spikes on PS2CLK.
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits,
                             input logic glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2data = fr[i];
            if (glitch && (i == 3 || i == 6)) begin
                wait_cyc(10); ps2clk = 1'b0; wait_cyc(3); ps2clk = 1'b1; wait_cyc(HALF - 13);
            end else begin
                wait_cyc(HALF);
            end
            ps2clk = 1'b0;
            if (glitch && (i == 5 || i == 8)) begin
                wait_cyc(10); ps2clk = 1'b1; wait_cyc(3); ps2clk = 1'b0; wait_cyc(HALF - 13);
            end else begin
                wait_cyc(HALF);
            end
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic glitch);
        send_bits(b, bad_par, 11, glitch);
        wait_cyc(4 * HALF);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        wait_cyc(5);
        n_cmp++;
        if (kb.kbstrobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", kb.kbstrobe); end
        n_cmp++;
        if (kb.kberr !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", kb.kberr); end
        n_cmp++;
        if (kb.kbcode !== 8'h00) begin n_bad++; $display("FAIL reset_code: got %h want 00", kb.kbcode); end
        arst = 1'b0;
        wait_cyc(20);
        n_cmp++;
        if (kb.kbcode !== 8'h00) begin n_bad++; $display("FAIL post_reset_code: got %h want 00", kb.kbcode); end
    endtask

    task automatic test_make();
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h1D, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL make_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++;
        if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL make_errs: got %0d want 0", err_cnt - e0); end
        n_cmp++;
        if (kb.kbcode !== 8'h1D) begin n_bad++; $display("FAIL make_code: got %h want 1d", kb.kbcode); end
    endtask

    task automatic test_break();
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 0) begin n_bad++; $display("FAIL break_strobes: got %0d want 0", strobe_cnt - s0); end
        n_cmp++;
        if (kb.kbcode !== 8'h1D) begin n_bad++; $display("FAIL break_code_held: got %h want 1d", kb.kbcode); end
        send_frame(8'h23, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL after_break_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++;
        if (kb.kbcode !== 8'h23) begin n_bad++; $display("FAIL after_break_code: got %h want 23", kb.kbcode); end
        n_cmp++;
        if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL break_errs: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_extended();
        int s0;
        s0 = strobe_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL ext_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++;
        if (kb.kbcode !== 8'h1B) begin n_bad++; $display("FAIL ext_code: got %h want 1b", kb.kbcode); end
        // Extended release: E0 F0 1B produces nothing.
        s0 = strobe_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 0) begin n_bad++; $display("FAIL ext_break_strobes: got %0d want 0", strobe_cnt - s0); end
    endtask

    task automatic test_parity_error();
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h23, 1'b1, 1'b0);
        n_cmp++;
        if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL parity_errs: got %0d want 1", err_cnt - e0); end
        n_cmp++;
        if (strobe_cnt - s0 != 0) begin n_bad++; $display("FAIL parity_strobes: got %0d want 0", strobe_cnt - s0); end
        n_cmp++;
        if (kb.kbcode !== 8'h1B) begin n_bad++; $display("FAIL parity_code_held: got %h want 1b", kb.kbcode); end
        send_frame(8'h1C, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL parity_recover_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++;
        if (kb.kbcode !== 8'h1C) begin n_bad++; $display("FAIL parity_recover_code: got %h want 1c", kb.kbcode); end
    endtask

    task automatic test_timeout();
        int s0, e0, waited;
        s0 = strobe_cnt; e0 = err_cnt;
        send_bits(8'h1D, 1'b0, 5, 1'b0);
        wait_cyc(TO / 2);
        n_cmp++;
        if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL timeout_early: got %0d errs want 0", err_cnt - e0); end
        waited = 0;
        while (err_cnt == e0 && waited < TO + 200) begin
            wait_cyc(1);
            waited++;
        end
        wait_cyc(5);
        n_cmp++;
        if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL timeout_errs: got %0d want 1", err_cnt - e0); end
        n_cmp++;
        if (strobe_cnt - s0 != 0) begin n_bad++; $display("FAIL timeout_strobes: got %0d want 0", strobe_cnt - s0); end
        send_frame(8'h1D, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL timeout_recover_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++;
        if (kb.kbcode !== 8'h1D) begin n_bad++; $display("FAIL timeout_recover_code: got %h want 1d", kb.kbcode); end
        n_cmp++;
        if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL timeout_recover_errs: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_glitch_and_typematic();
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL glitch_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++;
        if (kb.kbcode !== 8'h1C) begin n_bad++; $display("FAIL glitch_code: got %h want 1c", kb.kbcode); end
        n_cmp++;
        if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL glitch_errs: got %0d want 0", err_cnt - e0); end
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 3) begin n_bad++; $display("FAIL typematic_strobes: got %0d want 3", strobe_cnt - s0); end
    endtask

    task automatic test_arst_mid_frame();
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_bits(8'h1B, 1'b0, 4, 1'b0);
        wait_cyc(HALF / 2);
        arst = 1'b1;
        wait_cyc(3);
        n_cmp++;
        if (kb.kbcode !== 8'h00) begin n_bad++; $display("FAIL arst_code: got %h want 00", kb.kbcode); end
        n_cmp++;
        if (kb.kbstrobe !== 1'b0 || kb.kberr !== 1'b0) begin
            n_bad++; $display("FAIL arst_pulses: got strobe %b err %b want 0 0", kb.kbstrobe, kb.kberr);
        end
        arst = 1'b0;
        wait_cyc(TO + 200);
        n_cmp++;
        if (strobe_cnt - s0 != 0 || err_cnt - e0 != 0) begin
            n_bad++; $display("FAIL arst_quiet: got %0d strobes %0d errs want 0 0", strobe_cnt - s0, err_cnt - e0);
        end
        n_cmp++;
        if (kb.kbcode !== 8'h00) begin n_bad++; $display("FAIL arst_code_after: got %h want 00", kb.kbcode); end
        send_frame(KEY_S, 1'b0, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL arst_recover_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++;
        if (kb.kbcode !== 8'h1B) begin n_bad++; $display("FAIL arst_recover_code: got %h want 1b", kb.kbcode); end
    endtask

    task automatic test_pulse_shape();
        n_cmp++;
        if (long_cnt != 0) begin n_bad++; $display("FAIL pulse_width: got %0d long cycles want 0", long_cnt); end
        n_cmp++;
        if (both_cnt != 0) begin n_bad++; $display("FAIL strobe_err_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_error();
        test_timeout();
        test_glitch_and_typematic();
        test_arst_mid_frame();
        test_pulse_shape();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
